instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder: the inverse of the core's instruction decoder. Accepts field-level encode requests (format, opcode, funct3/funct7, register indices, full-width immediate) over a valid/ready handshake. Packs each request into a 32-bit RV32 instruction word, including B/J immediate bit scrambling and range checks. Expands a load-immediate pseudo-op into LUI/ADDI, buffers words in a FIFO and streams them to the fetch/inject path. Sits between debug/boot sequencing logic and the decode stage.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid_i  in  1  encode request valid
- req_ready_o  out  1  encoder can accept a request
- req_fmt_i  in  3  enc_fmt_t: R=0, I=1, S=2, B=3, U=4, J=5, LI=6, 7 reserved
- req_opcode_i  in  7  opcode field; ignored for LI
- req_funct3_i  in  3  funct3; ignored for U/J/LI
- req_funct7_i  in  7  funct7; used for R only
- req_rd_i / req_rs1_i / req_rs2_i  in  5 each  register indices; unused ones ignored per format
- req_imm_i  in  XLEN  immediate as full signed value (U: full upper value)
- instr_valid_o  out  1  FIFO head valid
- instr_ready_i  in  1  consumer takes head
- instr_o  out  32  FIFO head word; 0 when empty
- err_o  out  1  one-cycle pulse: last accepted request rejected
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Handshake: a request is accepted on a cycle with req_valid_i & req_ready_o. The consumer pops on a cycle with instr_valid_o & instr_ready_i.
- req_ready_o is high when FSM = IDLE and registered count_o < DEPTH. There is no combinational path from instr_ready_i.
- Packing follows the standard RV32 layouts:
  - R: funct7 at [31:25].
  - I: imm[11:0] at [31:20]. Shifts pass funct7 bits through imm, e.g. srai uses imm = 0x400|shamt.
  - S: imm[11:5] at [31:25], imm[4:0] at [11:7].
  - B: {imm[12], imm[10:5]} at [31:25], {imm[4:1], imm[11]} at [11:7].
  - U: imm[31:12] at [31:12].
  - J: {imm[20], imm[10:1], imm[11], imm[19:12]} at [31:12].
- Legality: a failing request is still accepted, nothing is pushed, and err_o pulses the next cycle.
  - I and S: imm[31:11] must be all equal.
  - B: imm[31:12] must be all equal, and imm[0]=0.
  - J: imm[31:20] must be all equal, and imm[0]=0.
  - U: imm[11:0] must be 0.
  - fmt 7 is always illegal.
- LI(rd, imm) computes hi = imm[31:12] + imm[11], modulo 2^20.
  - hi==0: single ADDI rd, x0, imm[11:0].
  - else if imm[11:0]==0: single LUI rd, hi.
  - else: LUI rd, hi followed by ADDI rd, rd, imm[11:0].
- FSM states:
  - IDLE: on an accepted two-word LI, push LUI and go to LI2 with the ADDI word latched.
  - LI2: req_ready_o=0. Push ADDI on the first cycle with a free slot (count_o<DEPTH, or =DEPTH with a pop that cycle), then return to IDLE.

## Timing
- Reset values: count_o=0, instr_valid_o=0, instr_o=0, err_o=0, FSM=IDLE. req_ready_o reads 1 while the FIFO is empty in IDLE.
- Latency: an accepted word appears on instr_o at the earliest the next cycle. There is no bypass; the FIFO is registered.
- A two-word LI produces its ADDI at the earliest one cycle after its LUI.
- Simultaneous push and pop: count is unchanged. When full, push is blocked by req_ready_o, even if a pop occurs the same cycle.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- instr_o is stable while instr_valid_o & ~instr_ready_i.
- Reset mid-operation (including LI2) flushes the FIFO and drops any pending ADDI.

## Structure
- Add to riscv_pkg: enc_fmt_t enum; LUI and ADDI opcode/funct3 constants, reusing the existing U_TYPE/I_TYPE opcodes.
- Sub-module enc_fifo: synchronous FIFO of DEPTH×32 with async active-high reset, exposing push/pop/count.
- The packing function and range checks are combinational in instr_encoder.

## Test plan
- R add rd=5, rs1=6, rs2=7 (opcode 0x33, f3=0, f7=0) -> instr_o=0x007302B3 one cycle later; err_o stays 0.
- B beq rs1=1, rs2=2, imm=0xFFFFFFFC -> 0xFE208EE3. The same request with imm=0x00000003 gives err_o pulse, count_o unchanged.
- LI rd=10:
  - imm=0x12345FFF -> 0x12346537, then 0xFFF50513.
  - imm=0xFFFFF800 -> single 0x80000513 (hi wraps to 0).
  - imm=0x00001000 -> single 0x00001537.
- Backpressure with DEPTH=4 and instr_ready_i=0:
  - After four pushes, req_ready_o=0.
  - One pop drops count_o to 3, with req_ready_o=1 the next cycle.
  - All words drain in order.
- LI with count_o=3 and no pop: LUI fills the FIFO and the FSM holds in LI2. ADDI is pushed in the cycle of the first pop.
- Assert rst in LI2 with 3 entries -> immediately count_o=0, instr_valid_o=0, instr_o=0. After release req_ready_o=1 and no ADDI appears.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 encoding constants and the encoder request format enum.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] U_TYPE = 7'b0110111;
    localparam logic [6:0] I_TYPE = 7'b0010011;

    localparam logic [6:0] OPC_LUI  = U_TYPE;
    localparam logic [6:0] OPC_ADDI = I_TYPE;
    localparam logic [2:0] F3_ADDI  = 3'b000;

    typedef enum logic [2:0] {
        FmtR    = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtLi   = 3'd6,
        FmtRsvd = 3'd7
    } enc_fmt_t;

    // True when bits [XLEN-1:lsb] are all equal, i.e. the value fits as a signed field.
    function automatic logic upper_uniform(input logic [XLEN-1:0] v, input int unsigned lsb);
        logic all1;
        logic all0;
        all1 = 1'b1;
        all0 = 1'b1;
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (i >= lsb) begin
                all1 &= v[i];
                all0 &= ~v[i];
            end
        end
        return all1 | all0;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Registered DEPTH x WIDTH FIFO; head reads as zero when empty.
module enc_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       head_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_en;

    assign valid_o = (count_q != '0);
    assign pop_en  = pop_i & valid_o;
    assign head_o  = valid_o ? mem[rd_ptr_q] : '0;
    assign count_o = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_en};
        end
    end

    // Push into a full FIFO is only issued alongside a pop, so the head slot is free to reuse.
    always_ff @(posedge clk) begin
        if (push_i) mem[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs field-level encode requests into RV32 words, expanding LI into LUI/ADDI,
// and streams the words out through a small FIFO.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [2:0]             req_fmt_i,
    input  logic [6:0]             req_opcode_i,
    input  logic [2:0]             req_funct3_i,
    input  logic [6:0]             req_funct7_i,
    input  logic [4:0]             req_rd_i,
    input  logic [4:0]             req_rs1_i,
    input  logic [4:0]             req_rs2_i,
    input  logic [XLEN-1:0]        req_imm_i,
    output logic                   instr_valid_o,
    input  logic                   instr_ready_i,
    output logic [31:0]            instr_o,
    output logic                   err_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef enum logic [0:0] {StIdle, StLi2} state_t;

    state_t      state_q;
    logic [31:0] addi_q;
    logic        err_q;

    enc_fmt_t    fmt;
    logic [31:0] word0;
    logic [31:0] word1;
    logic        legal;
    logic        two_words;
    logic [19:0] li_hi;
    logic [11:0] li_lo;
    logic        accept;
    logic        pop;
    logic        not_full;
    logic        push;
    logic [31:0] push_data;

    assign fmt = enc_fmt_t'(req_fmt_i);

    always_comb begin
        word0     = '0;
        word1     = '0;
        legal     = 1'b1;
        two_words = 1'b0;
        li_hi     = req_imm_i[31:12] + {19'b0, req_imm_i[11]};
        li_lo     = req_imm_i[11:0];
        unique case (fmt)
            FmtR: word0 = {req_funct7_i, req_rs2_i, req_rs1_i, req_funct3_i, req_rd_i,
                           req_opcode_i};
            FmtI: begin
                word0 = {req_imm_i[11:0], req_rs1_i, req_funct3_i, req_rd_i, req_opcode_i};
                legal = upper_uniform(req_imm_i, 11);
            end
            FmtS: begin
                word0 = {req_imm_i[11:5], req_rs2_i, req_rs1_i, req_funct3_i, req_imm_i[4:0],
                         req_opcode_i};
                legal = upper_uniform(req_imm_i, 11);
            end
            FmtB: begin
                word0 = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                         req_imm_i[4:1], req_imm_i[11], req_opcode_i};
                legal = upper_uniform(req_imm_i, 12) & ~req_imm_i[0];
            end
            FmtU: begin
                word0 = {req_imm_i[31:12], req_rd_i, req_opcode_i};
                legal = ~|req_imm_i[11:0];
            end
            FmtJ: begin
                word0 = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                         req_rd_i, req_opcode_i};
                legal = upper_uniform(req_imm_i, 20) & ~req_imm_i[0];
            end
            FmtLi: begin
                // hi absorbs the sign of the low 12 bits so LUI+ADDI rebuilds the full value.
                if (li_hi == '0) begin
                    word0 = {li_lo, 5'd0, F3_ADDI, req_rd_i, OPC_ADDI};
                end else begin
                    word0 = {li_hi, req_rd_i, OPC_LUI};
                    if (li_lo != '0) begin
                        two_words = 1'b1;
                        word1     = {li_lo, req_rd_i, F3_ADDI, req_rd_i, OPC_ADDI};
                    end
                end
            end
            FmtRsvd: legal = 1'b0;
        endcase
    end

    assign not_full    = (count_o < CW'(DEPTH));
    assign req_ready_o = (state_q == StIdle) & not_full;
    assign accept      = req_valid_i & req_ready_o;
    assign pop         = instr_valid_o & instr_ready_i;
    assign push        = (state_q == StLi2) ? (not_full | pop) : (accept & legal);
    assign push_data   = (state_q == StLi2) ? addi_q : word0;
    assign err_o       = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addi_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept & ~legal;
            unique case (state_q)
                StIdle: begin
                    if (accept & legal & two_words) begin
                        state_q <= StLi2;
                        addi_q  <= word1;
                    end
                end
                StLi2: begin
                    if (not_full | pop) state_q <= StIdle;
                end
            endcase
        end
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (instr_valid_o),
        .head_o      (instr_o),
        .count_o     (count_o)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder against an arithmetic reference model.
module tb_instr_encoder;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_fmt_i;
    logic [6:0]  req_opcode_i;
    logic [2:0]  req_funct3_i;
    logic [6:0]  req_funct7_i;
    logic [4:0]  req_rd_i;
    logic [4:0]  req_rs1_i;
    logic [4:0]  req_rs2_i;
    logic [31:0] req_imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic        err_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_pass   = 0;

    bit [31:0] exp_q[$];
    bit        pend;
    bit [31:0] pend_word;
    bit        err_exp;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_fmt_i     (req_fmt_i),
        .req_opcode_i  (req_opcode_i),
        .req_funct3_i  (req_funct3_i),
        .req_funct7_i  (req_funct7_i),
        .req_rd_i      (req_rd_i),
        .req_rs1_i     (req_rs1_i),
        .req_rs2_i     (req_rs2_i),
        .req_imm_i     (req_imm_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .err_o         (err_o),
        .count_o       (count_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // Reference encoder: ranges and field positions written as integer arithmetic.
    function automatic void model_encode(input logic [2:0] fmt, input logic [6:0] op,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm,
                                         output bit legal, output int nw,
                                         output bit [31:0] w0, output bit [31:0] w1);
        int        si;
        bit [31:0] u, rdf, rs1f, rs2f, f3f, opf, hi, lo;
        si   = imm;
        u    = imm;
        rdf  = 32'(rd) << 7;
        rs1f = 32'(rs1) << 15;
        rs2f = 32'(rs2) << 20;
        f3f  = 32'(f3) << 12;
        opf  = 32'(op);
        legal = 1'b1;
        nw = 1;
        w0 = 0;
        w1 = 0;
        case (fmt)
            3'd0: w0 = (32'(f7) << 25) | rs2f | rs1f | f3f | rdf | opf;
            3'd1: begin
                legal = (si >= -2048) && (si <= 2047);
                w0 = ((u & 32'hFFF) << 20) | rs1f | f3f | rdf | opf;
            end
            3'd2: begin
                legal = (si >= -2048) && (si <= 2047);
                w0 = (((u >> 5) & 32'h7F) << 25) | rs2f | rs1f | f3f | ((u & 32'h1F) << 7) | opf;
            end
            3'd3: begin
                legal = (si >= -4096) && (si <= 4095) && (si % 2 == 0);
                w0 = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | rs2f | rs1f | f3f
                   | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | opf;
            end
            3'd4: begin
                legal = (u % 4096 == 0);
                w0 = (u & 32'hFFFFF000) | rdf | opf;
            end
            3'd5: begin
                legal = (si >= -1048576) && (si <= 1048575) && (si % 2 == 0);
                w0 = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                   | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hFF) << 12) | rdf | opf;
            end
            3'd6: begin
                hi = ((u + 32'h800) >> 12) & 32'hFFFFF;
                lo = u & 32'hFFF;
                if (hi == 0) begin
                    w0 = (lo << 20) | rdf | 32'h13;
                end else begin
                    w0 = (hi << 12) | rdf | 32'h37;
                    if (lo != 0) begin
                        nw = 2;
                        w1 = (lo << 20) | (32'(rd) << 15) | rdf | 32'h13;
                    end
                end
            end
            default: legal = 1'b0;
        endcase
    endfunction

    // Cycle-level scoreboard: inputs are stable at the falling edge, updates mirror the next rise.
    always @(negedge clk) begin
        bit        ready_m, pop_m, lg;
        int        sz, nw;
        bit [31:0] w0, w1;
        if (rst) begin
            exp_q.delete();
            pend    = 1'b0;
            err_exp = 1'b0;
        end else begin
            sz      = exp_q.size();
            ready_m = !pend && (sz < DEPTH);
            check("count", count_o, sz);
            check("valid", instr_valid_o, sz > 0);
            check("head", instr_o, (sz > 0) ? exp_q[0] : 32'h0);
            check("ready", req_ready_o, ready_m);
            check("err", err_o, err_exp);
            err_exp = 1'b0;
            pop_m   = (sz > 0) && instr_ready_i;
            if (pop_m) void'(exp_q.pop_front());
            if (pend) begin
                if (sz < DEPTH || pop_m) begin
                    exp_q.push_back(pend_word);
                    pend = 1'b0;
                end
            end else if (req_valid_i && ready_m) begin
                model_encode(req_fmt_i, req_opcode_i, req_funct3_i, req_funct7_i, req_rd_i,
                             req_rs1_i, req_rs2_i, req_imm_i, lg, nw, w0, w1);
                if (!lg) begin
                    err_exp = 1'b1;
                end else begin
                    exp_q.push_back(w0);
                    if (nw == 2) begin
                        pend      = 1'b1;
                        pend_word = w1;
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm);
        bit acc = 1'b0;
        req_fmt_i    = fmt;
        req_opcode_i = op;
        req_funct3_i = f3;
        req_funct7_i = f7;
        req_rd_i     = rd;
        req_rs1_i    = rs1;
        req_rs2_i    = rs2;
        req_imm_i    = imm;
        req_valid_i  = 1'b1;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready_o;
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        check("accept", acc, 1'b1);
    endtask

    task automatic pop_one();
        instr_ready_i = 1'b1;
        @(posedge clk);
        #1;
        instr_ready_i = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk);
            #1;
            done = (count_o == 0);
        end
        instr_ready_i = 1'b0;
        check("drain_empty", count_o, 0);
    endtask

    initial begin
        int v;
        rst = 1'b1;
        req_valid_i = 1'b0;
        instr_ready_i = 1'b0;
        req_fmt_i = 0; req_opcode_i = 0; req_funct3_i = 0; req_funct7_i = 0;
        req_rd_i = 0; req_rs1_i = 0; req_rs2_i = 0; req_imm_i = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count_o, 0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_instr", instr_o, 0);
        check("rst_err", err_o, 0);
        rst = 1'b0;
        #1;
        check("rst_ready", req_ready_o, 1);

        send(3'd0, 7'h33, 3'd0, 7'd0, 5'd5, 5'd6, 5'd7, 32'h0);
        check("r_add", instr_o, 32'h007302B3);
        check("r_add_err", err_o, 0);
        drain();

        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
        check("b_beq", instr_o, 32'hFE208EE3);
        drain();
        send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'h00000003);
        check("b_bad_err", err_o, 1);
        check("b_bad_count", count_o, 0);
        @(posedge clk); #1;
        check("b_bad_err_clear", err_o, 0);

        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        check("li_lui", instr_o, 32'h12346537);
        @(posedge clk); #1;
        check("li_two_count", count_o, 2);
        pop_one();
        check("li_addi", instr_o, 32'hFFF50513);
        drain();
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'hFFFFF800);
        check("li_wrap", instr_o, 32'h80000513);
        @(posedge clk); #1;
        check("li_wrap_count", count_o, 1);
        drain();
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h00001000);
        check("li_lui_only", instr_o, 32'h00001537);
        @(posedge clk); #1;
        check("li_lui_only_count", count_o, 1);
        drain();

        for (int i = 0; i < 4; i++)
            send(3'd1, 7'h13, 3'd0, 7'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
        check("full_count", count_o, 4);
        check("full_ready", req_ready_o, 0);
        pop_one();
        check("pop_count", count_o, 3);
        check("pop_ready", req_ready_o, 1);
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        repeat (3) begin
            check("li2_hold_count", count_o, 4);
            check("li2_hold_ready", req_ready_o, 0);
            @(posedge clk); #1;
        end
        pop_one();
        check("li2_push_count", count_o, 4);
        check("li2_push_ready", req_ready_o, 0);
        pop_one();
        check("li2_done_ready", req_ready_o, 1);
        drain();

        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h1);
        send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'h2);
        send(3'd6, 7'h00, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h12345FFF);
        check("pre_rst_count", count_o, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_count", count_o, 0);
        check("mid_rst_valid", instr_valid_o, 0);
        check("mid_rst_instr", instr_o, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("post_rst_ready", req_ready_o, 1);
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_count", count_o, 0);
        check("post_rst_valid", instr_valid_o, 0);

        for (int c = 0; c < 1500; c++) begin
            req_valid_i   = ($urandom_range(0, 9) < 6);
            instr_ready_i = ($urandom_range(0, 1) == 1);
            req_fmt_i     = 3'($urandom_range(0, 7));
            req_opcode_i  = 7'($urandom);
            req_funct3_i  = 3'($urandom);
            req_funct7_i  = 7'($urandom);
            req_rd_i      = 5'($urandom);
            req_rs1_i     = 5'($urandom);
            req_rs2_i     = 5'($urandom);
            case ($urandom_range(0, 4))
                0: v = int'($urandom_range(0, 8191)) - 4096;
                1: v = int'($urandom_range(0, 4194303)) - 2097152;
                2: v = int'($urandom & 32'hFFFFF000);
                3: v = int'($urandom);
                default: v = int'($urandom_range(0, 4095)) + (int'($urandom_range(0, 3)) << 12)
                           - 2048;
            endcase
            if ($urandom_range(0, 1) == 1) v = v & ~1;
            req_imm_i = v;
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
